mul_iter: RTL

//   Multi-cycle radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.

---
 rtl/mul_iter_pkg.sv | 36 +++
 rtl/mul_step.sv | 17 +
 rtl/mul_iter.sv | 112 +++++++++++
 3 files changed

// File: rtl/mul_iter_pkg.sv
// Shared definitions for the iterative RV32M multiplier: operand width,
// op encodings, FSM state codes and two's-complement sign helpers.
package mul_iter_pkg;

    localparam int XLEN  = 32;
    localparam int STEPS = XLEN;
    localparam int CNT_W = $clog2(STEPS);

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

    // Magnitude of an operand. A negative value is negated only when the
    // operand is treated as signed. 0x80000000 maps to 2^31, which still
    // fits because the magnitude is kept unsigned.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v,
                                            input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
    endfunction

    // Restores the sign of the unsigned 64-bit magnitude product.
    function automatic logic [2*XLEN-1:0] apply_sign(input logic [2*XLEN-1:0] p,
                                                     input logic              neg);
        return neg ? (~p + (2*XLEN)'(1)) : p;
    endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add step: conditionally adds the shifted multiplicand into the
// accumulator when the current multiplier bit is set.
module mul_step
    import mul_iter_pkg::*;
(
    input  logic [2*XLEN-1:0] acc,
    input  logic [2*XLEN-1:0] mcand,
    input  logic              add_en,
    output logic [2*XLEN-1:0] acc_next
);

    // Accumulate the partial product for this multiplier bit.
    always_comb begin
        acc_next = add_en ? (acc + mcand) : acc;
    end

endmodule

// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Multiplies operand magnitudes over 32 steps, then fixes the sign and
// returns the low or high half with a one-cycle done pulse.
// Optional feature: define MUL_EARLY_TERM_EN to leave CALC as soon as the
// remaining multiplier bits are all zero (latency 2..33 instead of 33).
module mul_iter
    import mul_iter_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] x_i,
    input  logic [XLEN-1:0] y_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] z_o
);

    mul_state_e        state;
    mul_op_e           op_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [CNT_W-1:0]  cnt;

    logic              x_signed;
    logic              y_signed;
    logic              neg_in;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;
    logic              calc_last;

    mul_step u_step (
        .acc      (acc),
        .mcand    (mcand),
        .add_en   (mplier[0]),
        .acc_next (acc_next)
    );

    // Operand signedness from the incoming op, and the final sign of the product.
    always_comb begin
        x_signed = (op_i == MUL_OP_MULH) || (op_i == MUL_OP_MULHSU);
        y_signed = (op_i == MUL_OP_MULH);
        neg_in   = (x_signed & x_i[XLEN-1]) ^ (y_signed & y_i[XLEN-1]);
        prod     = apply_sign(acc, neg_q);
    end

    // Decide whether the current CALC cycle is the last add step.
    always_comb begin
`ifdef MUL_EARLY_TERM_EN
        // Bits above bit 0 are what remains after this step; if none are set
        // the accumulator is already final.
        calc_last = (cnt == '0) || (mplier[XLEN-1:1] == '0);
`else
        calc_last = (cnt == '0);
`endif
    end

    // Control FSM and datapath registers; outputs are registered.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            z_o    <= '0;
            op_q   <= MUL_OP_MUL;
            neg_q  <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        op_q   <= mul_op_e'(op_i);
                        neg_q  <= neg_in;
                        acc    <= '0;
                        mcand  <= {{XLEN{1'b0}}, mag(x_i, x_signed)};
                        mplier <= mag(y_i, y_signed);
                        cnt    <= CNT_W'(STEPS - 1);
                        busy_o <= 1'b1;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    if (calc_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The low half is the same for every op, so only MUL takes it.
                    z_o    <= (op_q == MUL_OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
